// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared constants for the N:1 round-robin / fixed-select mux.
//   MODE_RR / MODE_FIXED : encodings of the rr_mux_nto1 'mode' input
//   RR_MUX_N_DEF         : default channel count
//   RR_MUX_WIDTH_DEF     : default data width per channel
package rr_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  localparam int RR_MUX_N_DEF     = 4;
  localparam int RR_MUX_WIDTH_DEF = 8;

endpackage : rr_mux_pkg

// File: rtl/rr_mux_nto1_arbiter.sv
// rr_arbiter: combinational rotate-priority arbiter.
// The search starts at channel 'ptr' and moves upward, wrapping from N-1 to 0.
// The first requesting channel found is granted.
//   req [N]  : request vector
//   ptr [CW] : highest-priority channel index (must be < N)
//   gnt [N]  : one-hot grant (all zero when there is no request)
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int N  = RR_MUX_N_DEF,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  always_comb begin
    logic        found;
    int unsigned idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      // Wrap by subtraction rather than modulo, so a non-power-of-two N
      // still produces a valid index.
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/rr_mux_nto1.sv
// rr_mux_nto1: N-input, WIDTH-bit multiplexer with a registered output.
// Each input channel uses a valid/ready handshake.
// Selection is either round-robin (mode=MODE_RR) or a fixed channel given
// by 'sel' (mode=MODE_FIXED).
// Optional macro RR_MUX_PARITY_EN adds out_par, the registered XOR-reduce
// (even parity) of out_data.
//   clk, rst_n : clock, synchronous active-low reset
//   mode, sel  : selection mode and fixed-select channel index
//   in_valid   : per-channel valid
//   in_data    : flattened channel data; channel i is [i*WIDTH +: WIDTH]
//   in_ready   : per-channel ready (combinational, at most one bit set)
//   out_valid  : output register holds a word
//   out_ready  : consumer accepts the word
//   out_data   : registered data
//   out_ch     : registered source-channel index
//   out_par    : registered parity of out_data (RR_MUX_PARITY_EN only)
module rr_mux_nto1
  import rr_mux_pkg::*;
#(
  parameter  int N     = RR_MUX_N_DEF,
  parameter  int WIDTH = RR_MUX_WIDTH_DEF,
  localparam int CW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [CW-1:0]    sel,
  input  logic [N-1:0]     in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_ch
`ifdef RR_MUX_PARITY_EN
  ,
  output logic             out_par
`endif
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [CW-1:0]    out_ch_q,    out_ch_d;
  logic [CW-1:0]    rr_ptr_q,    rr_ptr_d;

  logic             load;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic             xfer;
  logic [CW-1:0]    gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  // The output register can accept a word when it is empty or being drained.
  assign load = !out_valid_q || out_ready;

  // Eligibility masking. In fixed mode, only the channel that matches 'sel'
  // can request. An out-of-range 'sel' matches no channel, so nothing
  // is eligible.
  always_comb begin
    req = '0;
    if (mode == MODE_RR) begin
      req = in_valid;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        req[i] = in_valid[i] && (int'(sel) == i);
      end
    end
  end

  // In fixed mode, req has at most one bit set. The arbiter then grants
  // that bit whatever the pointer value, so both modes share one grant path.
  rr_arbiter #(
    .N (N)
  ) u_arb (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  assign in_ready = rst_n ? (gnt & {N{load}}) : '0;
  assign xfer     = |(in_valid & in_ready);

  // One-hot grant to channel index and data.
  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt[i]) begin
        gnt_idx  = CW'(i);
        gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_ch_d    = gnt_idx;
      rr_ptr_d    = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

`ifdef RR_MUX_PARITY_EN
  logic out_par_q, out_par_d;

  // Parity is computed from the incoming word, so it stays aligned with out_data.
  assign out_par_d = xfer ? ^gnt_data : out_par_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_par_q <= 1'b0;
    end else begin
      out_par_q <= out_par_d;
    end
  end

  assign out_par = out_par_q;
`endif

endmodule : rr_mux_nto1
